// File: rtl/uart_rx_frame.sv
// UART receive framer: synchronises rx, detects the start edge, samples each bit
// on the baud generator's mid-bit strobe and emits one byte per frame with an error flag.
module uart_rx_frame #(
    parameter int PARITY = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       bps_clk,
    output logic       bps_en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err
);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    localparam logic PAR_ODD = (PARITY == 1);

    state_t     state, state_nxt;
    logic       s1, s2, s3;
    logic       start_edge;
    logic [7:0] shreg;
    logic [2:0] cnt;
    logic       par_err;

    // s2 is the sampled line; s3 only exists to detect the 1->0 transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= rx;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign start_edge = s3 & ~s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start_edge) state_nxt = START;
            START: if (bps_clk)    state_nxt = s2 ? IDLE : DATA;
            DATA:  if (bps_clk && cnt == 3'd7) state_nxt = (PARITY != 0) ? PAR : STOP;
            PAR:   if (bps_clk)    state_nxt = STOP;
            STOP:  if (bps_clk)    state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bps_en = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= 8'h00;
            cnt      <= 3'd0;
            par_err  <= 1'b0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: if (start_edge) begin
                    cnt     <= 3'd0;
                    par_err <= 1'b0;
                end
                DATA: if (bps_clk) begin
                    shreg[cnt] <= s2;
                    cnt        <= cnt + 3'd1;
                end
                PAR: if (bps_clk) begin
                    par_err <= ((^shreg) ^ s2) != PAR_ODD;
                end
                STOP: if (bps_clk) begin
                    // errored frames still publish their data
                    rx_data  <= shreg;
                    rx_err   <= ~s2 | par_err;
                    rx_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Serial-to-parallel UART receive framer. Sits directly downstream of the team's receive baud generator: it detects the start edge on the `rx` line and raises `bps_en`. It then samples on each mid-bit `bps_clk` strobe and delivers one 8-bit byte per frame with a one-cycle valid pulse and a frame/parity error flag. Its output feeds the receive FIFO / command parser.

## Interface
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even; other values are illegal.
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `rx` input 1: asynchronous serial line, idle high.
- `bps_clk` input 1: one-cycle mid-bit strobe from the baud generator.
  - First strobe arrives half a bit period after `bps_en` rises.
  - Subsequent strobes arrive every bit period.
- `bps_en` output 1: baud generator enable; high for the whole frame.
- `rx_data` output 8: last received byte, LSB first on the line.
- `rx_valid` output 1: one-cycle pulse, frame complete.
- `rx_err` output 1: qualifies `rx_valid`.
  - 1 = stop bit low or parity mismatch.
  - Held until the next `rx_valid`.

## Operation
- Input conditioning:
  - `rx` passes through a 3-flop chain `s1→s2→s3`; all three reset to 1.
  - Sampled value is `s2`.
  - Start edge = `s3 & ~s2`.
- State machine, encoded states IDLE, START, DATA, PAR, STOP:
  - IDLE:
    - `bps_en`=0.
    - On start edge: `bps_en`←1, clear bit counter → START.
  - START, on `bps_clk`:
    - If `s2`=0 → DATA.
    - Else false start: `bps_en`←0 → IDLE, no `rx_valid`.
  - DATA, on `bps_clk`:
    - Shift `s2` into bit[cnt], cnt++ (3-bit counter).
    - After bit 7: → PAR if `PARITY`≠0, else → STOP.
  - PAR, on `bps_clk`:
    - Capture `s2`.
    - Parity error = (XOR of data bits ^ captured bit) ≠ expected.
    - Expected = 1 for odd, 0 for even → STOP.
  - STOP, on `bps_clk`:
    - `rx_data`←shift register.
    - `rx_err`←(`s2`==0) | parity error.
    - `rx_valid`←1 for one cycle.
    - `bps_en`←0 → IDLE.
- `rx_data` is updated on every completed frame, including errored frames.
- `rx_valid`, `rx_data` and `rx_err` are registered outputs.
- Start edges outside IDLE are ignored.
- `bps_clk` pulses outside START/DATA/PAR/STOP are ignored.
- A start edge in the same cycle the FSM returns to IDLE is not seen. The next start is detected from IDLE once `s3`/`s2` show a 1→0 transition; the stop bit is high, so normal back-to-back frames are caught.
- A break condition (line held low) yields a frame with `rx_data`=0x00 and `rx_err`=1. The FSM then waits in IDLE for a new 1→0 edge; a held-low line does not retrigger.

## Timing
- Reset values:
  - `bps_en`=0, `rx_data`=0x00, `rx_valid`=0, `rx_err`=0.
  - State IDLE, sync flops=1, shift register=0, counter=0.
- Reset mid-frame aborts immediately. No `rx_valid` is produced, and `bps_en` is low in the first cycle of reset.
- Start detection: `bps_en` rises 3 clocks after the `rx` falling edge (2 sync + 1 register).
- Sample point is the `bps_clk` cycle itself; the state transition is registered on that edge.
- `rx_valid` is high the cycle after the STOP-state `bps_clk` strobe.
  - `bps_en` falls in the same cycle `rx_valid` rises.
- Frame length in strobes: 10 without parity, 11 with parity.
- Glitch rejection: a low pulse that is high again at the START strobe is rejected.

## Test plan
- `PARITY`=0, 16 clocks/bit; bench pairs this block with the baud generator. Send 0xA5 → `rx_data`=0xA5, `rx_valid` exactly 1 cycle, `rx_err`=0, `bps_en` low afterwards.
- 3-clock low glitch on an idle line → `bps_en` pulses high then drops after the START strobe; no `rx_valid`; `rx_data` unchanged.
- Send 0x3C with stop bit driven 0 → `rx_data`=0x3C, `rx_err`=1. A following correct 0x3C frame gives `rx_err`=0.
- `PARITY`=2: 0x07 with parity bit 1 → `rx_err`=0. Same data with parity bit 0 → `rx_err`=1. Repeat with `PARITY`=1 and inverted expectations.
- Back-to-back frames 0x00, 0xFF, 0x55 with no idle gap beyond the stop bit → three `rx_valid` pulses, data in order, no errors.
- Assert `rst_n` low during data bit 4 of a frame → all outputs at reset values. Release during idle and send 0x81 → `rx_data`=0x81 and a single `rx_valid`.
